// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a registered 2-entry output FIFO and a saturating accept counter.
// Optional feature: define IMM_GEN_ZIMM_EN to decode CSR zero-extended immediates (fmt Z).
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       fmt,
  output logic             illegal,
  output logic [CNT_W-1:0] dec_cnt
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
  } entry_t;

  entry_t      dec;
  logic [31:0] dec_imm32;
  fmt_e        dec_fmt;
  logic        dec_illegal;

  entry_t      mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic        push;
  logic        pop;
  entry_t      head;

  // Decode into a 32-bit immediate first; every format is defined in 32 bits
  // and then sign-extended once, so XLEN=32 and XLEN=64 share one path.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    dec_imm32   = '0;
    dec_fmt     = FMT_NONE;
    dec_illegal = (inst[1:0] != 2'b11);
    case (inst[6:2])
      5'b00000, 5'b00100, 5'b00110, 5'b11001: begin
        dec_fmt   = FMT_I;
        dec_imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      5'b01000: begin
        dec_fmt   = FMT_S;
        dec_imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      5'b11000: begin
        dec_fmt   = FMT_B;
        dec_imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      5'b00101, 5'b01101: begin
        dec_fmt   = FMT_U;
        dec_imm32 = {inst[31:12], 12'b0};
      end
      5'b11011: begin
        dec_fmt   = FMT_J;
        dec_imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
`ifdef IMM_GEN_ZIMM_EN
      5'b11100: begin
        if (inst[14]) begin
          dec_fmt   = FMT_Z;
          dec_imm32 = {27'b0, inst[19:15]};
        end
      end
`else
`endif
      default: ;
    endcase
    if (dec_illegal) begin
      dec_fmt   = FMT_NONE;
      dec_imm32 = '0;
    end
    dec.imm     = XLEN'($signed(dec_imm32));
    dec.fmt     = dec_fmt;
    dec.illegal = dec_illegal;
  end

  // Gating with rst_n keeps the producer stalled for the whole reset window.
  assign in_ready  = rst_n && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // NOTE: the FIFO storage has no reset; entries are only visible through out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= dec;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= 2'd0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      dec_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (push && (dec_cnt != {CNT_W{1'b1}})) begin
        dec_cnt <= dec_cnt + CNT_W'(1);
      end
    end
  end

  // Empty FIFO drives all-zero data rather than stale storage.
  assign head    = out_valid ? mem[rd_ptr] : '0;
  assign imm     = head.imm;
  assign fmt     = head.fmt;
  assign illegal = head.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: directed vectors queue their expected entry,
// a negedge monitor pops and compares on every output transfer.
module tb_imm_gen_pipe;

  localparam int XLEN  = 64;
  localparam int CNT_W = 3;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      inst;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm;
  logic [2:0]       fmt;
  logic             illegal;
  logic [CNT_W-1:0] dec_cnt;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t exp_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;

  imm_gen_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inst      (inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .imm       (imm),
    .fmt       (fmt),
    .illegal   (illegal),
    .dec_cnt   (dec_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] i, input logic [2:0] f, input logic il);
    exp_t e;
    e.imm = i;
    e.fmt = f;
    e.ill = il;
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input logic [31:0] w, input exp_t e);
    int n;
    n        = 0;
    in_valid = 1'b1;
    inst     = w;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check("push_timeout", 64'd0, 64'd1);
    end else begin
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n         = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_out_valid", 64'(out_valid), 64'd0);
    check("empty_imm_zero", imm, 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("imm", imm, e.imm);
        check("fmt", 64'(fmt), 64'(e.fmt));
        check("illegal", 64'(illegal), 64'(e.ill));
      end
    end
  end

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    inst      = '0;
    out_ready = 1'b0;

    #3;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_dec_cnt", 64'(dec_cnt), 64'd0);
    check("rst_imm", imm, 64'd0);
    check("rst_fmt", 64'(fmt), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    #19 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // I-format -1 with the consumer ready.
    out_ready = 1'b1;
    push(32'hFFF00093, mk(64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0));
    check("i_out_valid", 64'(out_valid), 64'd1);
    check("i_dec_cnt", 64'(dec_cnt), 64'd1);

    push(32'h0050_0093, mk(64'd5, 3'd1, 1'b0));                        // addi x1,x0,5
    push(32'hFE20_AC23, mk(64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 1'b0));      // sw, offset -8
    push(32'h0000_0863, mk(64'd16, 3'd3, 1'b0));                       // beq, offset +16
    push(32'h8000_00B7, mk(64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0));      // lui 0x80000
    push(32'hFFDF_F06F, mk(64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 1'b0));      // jal -4
    push(32'h0000_0033, mk(64'd0, 3'd0, 1'b0));                        // R-type: no imm
    push(32'h0000_0000, mk(64'd0, 3'd0, 1'b1));                        // illegal
    push(32'hFFF0_0090, mk(64'd0, 3'd0, 1'b1));                        // illegal I-shape
`ifdef IMM_GEN_ZIMM_EN
    push(32'h340F_D073, mk(64'd31, 3'd6, 1'b0));
`else
    push(32'h340F_D073, mk(64'd0, 3'd0, 1'b0));
`endif
    push(32'h3402_9073, mk(64'd0, 3'd0, 1'b0));                        // csrrw: no zimm
    drain();
    check("dec_cnt_saturated", 64'(dec_cnt), 64'(exp_cnt));
    check("dec_cnt_all_ones", 64'(dec_cnt), 64'd7);

    // Back-pressure: two fill the FIFO, the third waits.
    out_ready = 1'b0;
    push(32'h0010_0093, mk(64'd1, 3'd1, 1'b0));
    push(32'h0020_0093, mk(64'd2, 3'd1, 1'b0));
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b1;
    inst     = 32'h0030_0093;
    exp_q.push_back(mk(64'd3, 3'd1, 1'b0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_held", 64'(in_ready), 64'd0);
      check("bp_stable_imm", imm, 64'd1);
      check("bp_stable_fmt", 64'(fmt), 64'd1);
    end
    out_ready = 1'b1;
    begin
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("bp_ready_again", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    drain();

    // Mid-operation reset with two entries queued.
    out_ready = 1'b0;
    push(32'h0040_0093, mk(64'd4, 3'd1, 1'b0));
    push(32'h0050_0093, mk(64'd5, 3'd1, 1'b0));
    check("pre_rst_full", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_dec_cnt", 64'(dec_cnt), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_imm", imm, 64'd0);
    exp_q.delete();
    exp_cnt = 0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);
    check("rel_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    push(32'h800000B7, mk(64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0));
    check("rel_dec_cnt", 64'(dec_cnt), 64'd1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width; only 32 and 64 are legal.
REQ-002 SHALL have parameter CNT_W, default 16, width of the accepted-instruction counter.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit; reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit; an instruction is offered.
REQ-006 SHALL have port in_ready, output, 1 bit; the block can accept an instruction.
REQ-007 SHALL have port inst, input, 32 bits; the instruction word.
REQ-008 SHALL have port out_valid, output, 1 bit; the head entry is valid.
REQ-009 SHALL have port out_ready, input, 1 bit; the consumer accepts the head entry.
REQ-010 SHALL have port imm, output, XLEN bits; the sign-extended immediate.
REQ-011 SHALL have port fmt, output, 3 bits; format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
REQ-012 SHALL have port illegal, output, 1 bit; inst[1:0] != 2'b11.
REQ-013 SHALL have port dec_cnt, output, CNT_W bits; count of accepted instructions.

Function
REQ-014 SHALL decode on inst[6:2] as follows.
- I format: 00000, 00100, 00110, 11001; immediate is inst[31:20].
- S format: 01000; immediate is {inst[31:25], inst[11:7]}.
- B format: 11000; immediate is {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- U format: 00101, 01101; immediate is {inst[31:12], 12'b0}.
- J format: 11011; immediate is {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- All other opcodes: fmt NONE, imm 0.
REQ-015 SHALL sign-extend the I/S/B/U/J immediates from inst[31] to the full XLEN bits, with no truncation or garbage bits.
REQ-016 SHALL force imm to 0, fmt to NONE and illegal to 1 when illegal is set; the entry is still queued.
REQ-017 SHALL use a handshake: a transfer occurs on a rising clk edge where valid and ready are both 1.
REQ-018 SHALL register each decoded result into a 2-entry FIFO (occupancy 0, 1 or 2).
- An accepted instruction appears at the head no earlier than the next cycle.
- There is no combinational in-to-out path.
REQ-019 SHALL drive in_ready = (occupancy < 2), which is independent of out_ready.
REQ-020 SHALL, at occupancy 1 with a push and a pop in the same cycle, keep occupancy at 1 and present the new entry next cycle.
REQ-021 SHALL hold imm, fmt and illegal stable while out_valid=1 and out_ready=0.
REQ-022 SHALL drive out_valid = (occupancy > 0); the data outputs are 0 when the FIFO is empty.
REQ-023 SHALL increment dec_cnt on each input transfer, saturating at all-ones with no wrap.
REQ-024 SHALL preserve FIFO order; the read and write pointers wrap modulo 2.

Reset
REQ-025 SHALL, while rst_n=0, immediately set occupancy to 0, out_valid to 0, imm/fmt/illegal to 0 and dec_cnt to 0.
REQ-026 SHALL hold in_ready at 0 while rst_n=0.
REQ-027 SHALL discard all queued entries on a mid-operation reset.
REQ-028 SHALL make in_ready 1 in the first cycle after rst_n deasserts.

Configuration
REQ-029 SHALL provide the CSR immediate feature under macro IMM_GEN_ZIMM_EN.
- Defined: opcode 11100 with inst[14]=1 yields fmt Z, imm = zero-extended inst[19:15].
- Defined: opcode 11100 with inst[14]=0 yields fmt NONE, imm 0.
- Undefined: all opcode 11100 instructions yield fmt NONE, imm 0, and code 6 is never produced.

Verification
REQ-030 SHALL cover this I-format case with XLEN=64: push inst 0xFFF00093 with out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFFFFFFFFFF, fmt=1, dec_cnt=1.
REQ-031 SHALL cover U and J formats.
- LUI 0x800000B7 -> imm=0xFFFFFFFF80000000 at XLEN=64 and 0x80000000 at XLEN=32, fmt=4.
- JAL 0xFFDFF06F -> imm = all-ones except bit1:0=00 (i.e. -4), fmt=5.
REQ-032 SHALL cover back-pressure: hold out_ready=0 and push 3 instructions -> in_ready=0 after 2 accepts, the third is held, and the outputs stay stable.
- Then raise out_ready -> entries pop in order, and the third is accepted and emitted last.
REQ-033 SHALL cover the CSR immediate: with IMM_GEN_ZIMM_EN defined, push 0x340FD073 -> imm=31, fmt=6.
- Without the macro -> imm=0, fmt=0.
REQ-034 SHALL cover illegal input and mid-operation reset.
- Push 0x00000000 -> illegal=1, imm=0, fmt=0.
- Pulse rst_n low with 2 entries queued -> out_valid=0 and dec_cnt=0 immediately, and in_ready=1 after release.
